// File: rtl/cornice_multi.sv
`default_nettype none
//==============================================================================
// Module   : cornice_multi
// Desc     : NUM_BOX moving boxes with per-frame motion. Each pixel is tested for a hit on a
//            box border or interior. The result is produced by a 2-stage pipeline.
//            Define CORNICE_RIEMPI_EN to add per-box fill flags (LOAD_FILL port).
// Revision : 1.0 - initial release
//==============================================================================
module cornice_multi #(
    parameter int NUM_BOX   = 4,
    parameter int H         = 1280,
    parameter int V         = 1024,
    parameter int LARGHEZZA = 100,
    parameter int ALTEZZA   = 100,
    parameter int SPESSORE  = 6,
    parameter int VW        = 6,
    localparam int IW       = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 FRAME_START,
    input  logic                 LOAD,
    input  logic [IW-1:0]        LOAD_SEL,
    input  logic [10:0]          LOAD_X,
    input  logic [10:0]          LOAD_Y,
    input  logic signed [VW-1:0] LOAD_VX,
    input  logic signed [VW-1:0] LOAD_VY,
`ifdef CORNICE_RIEMPI_EN
    input  logic                 LOAD_FILL,
`endif
    input  logic                 PIX_VALID,
    input  logic [10:0]          X_CONTROLLO,
    input  logic [10:0]          Y_CONTROLLO,
    output logic                 OUT_VALID,
    output logic                 CONFERMA,
    output logic                 INTERNO,
    output logic [IW-1:0]        INDICE
);

    localparam logic signed [12:0]   c_h_s     = 13'(H);
    localparam logic signed [12:0]   c_ymax_s  = 13'(V - ALTEZZA);
    localparam logic [12:0]          c_h       = 13'(H);
    localparam logic [12:0]          c_2h      = 13'(2 * H);
    localparam logic [12:0]          c_larg    = 13'(LARGHEZZA);
    localparam logic [12:0]          c_sp      = 13'(SPESSORE);
    localparam logic [12:0]          c_larg_sp = 13'(LARGHEZZA - SPESSORE);
    localparam logic [11:0]          c_alt     = 12'(ALTEZZA);
    localparam logic [11:0]          c_sp12    = 12'(SPESSORE);
    localparam logic [11:0]          c_alt_sp  = 12'(ALTEZZA - SPESSORE);
    localparam logic [10:0]          c_xmax    = 11'(H - 1);
    localparam logic [10:0]          c_ymax    = 11'(V - ALTEZZA);
    localparam logic signed [VW-1:0] c_v_min   = {1'b1, {(VW-1){1'b0}}};
    localparam logic signed [VW-1:0] c_v_max   = {1'b0, {(VW-1){1'b1}}};

    // Velocity reversal; the most negative value has no positive twin, so saturate.
    function automatic logic signed [VW-1:0] neg_sat(input logic signed [VW-1:0] vy);
        return (vy == c_v_min) ? c_v_max : -vy;
    endfunction

    function automatic logic [10:0] step_x(input logic [10:0] x, input logic signed [VW-1:0] vx);
        logic signed [12:0] w_xs;
        w_xs = $signed({2'b00, x}) + $signed({{(13-VW){vx[VW-1]}}, vx});
        if (w_xs < 13'sd0) begin
            w_xs = w_xs + c_h_s;
        end else if (w_xs >= c_h_s) begin
            w_xs = w_xs - c_h_s;
        end
        return w_xs[10:0];
    endfunction

    // Returns {vy_next, y_next}
    function automatic logic [VW+10:0] step_y(input logic [10:0] y, input logic signed [VW-1:0] vy);
        logic signed [12:0] w_ys;
        logic [VW+10:0]     w_res;
        w_ys = $signed({2'b00, y}) + $signed({{(13-VW){vy[VW-1]}}, vy});
        if (w_ys < 13'sd0) begin
            w_res = {neg_sat(vy), 11'd0};
        end else if (w_ys > c_ymax_s) begin
            w_res = {neg_sat(vy), c_ymax};
        end else begin
            w_res = {vy, w_ys[10:0]};
        end
        return w_res;
    endfunction

    // Returns {outer, inner}; dx is taken modulo H so boxes straddling x=H wrap onto x=0.
    function automatic logic [1:0] hit_flags(input logic [10:0] bx, input logic [10:0] by,
                                             input logic [10:0] px, input logic [10:0] py);
        logic [12:0] w_dx;
        logic [11:0] w_yp;
        logic [11:0] w_yb;
        logic        w_out;
        logic        w_in;
        w_dx = {2'b00, px} + c_h - {2'b00, bx};
        if (w_dx >= c_2h) begin
            w_dx = w_dx - c_2h;
        end else if (w_dx >= c_h) begin
            w_dx = w_dx - c_h;
        end
        w_yp  = {1'b0, py};
        w_yb  = {1'b0, by};
        w_out = (w_dx < c_larg) && (w_yp >= w_yb) && (w_yp < w_yb + c_alt);
        w_in  = (w_dx >= c_sp) && (w_dx < c_larg_sp) &&
                (w_yp >= w_yb + c_sp12) && (w_yp < w_yb + c_alt_sp);
        return {w_out, w_in};
    endfunction

    logic [10:0]          r_x  [NUM_BOX];
    logic [10:0]          r_y  [NUM_BOX];
    logic signed [VW-1:0] r_vx [NUM_BOX];
    logic signed [VW-1:0] r_vy [NUM_BOX];
    logic [10:0]          w_x_nxt  [NUM_BOX];
    logic [10:0]          w_y_nxt  [NUM_BOX];
    logic signed [VW-1:0] w_vx_nxt [NUM_BOX];
    logic signed [VW-1:0] w_vy_nxt [NUM_BOX];
    logic [10:0]          w_load_x;
    logic [10:0]          w_load_y;
    logic [NUM_BOX-1:0]   w_outer;
    logic [NUM_BOX-1:0]   w_inner;
    logic                 r_s1_valid;
    logic [NUM_BOX-1:0]   r_s1_outer;
    logic [NUM_BOX-1:0]   r_s1_inner;
    logic                 w_hit;
    logic                 w_win_inner;
    logic                 w_win_fill;
    logic [IW-1:0]        w_win_idx;
    logic                 r_out_valid;
    logic                 r_conferma;
    logic                 r_interno;
    logic [IW-1:0]        r_indice;
`ifdef CORNICE_RIEMPI_EN
    logic [NUM_BOX-1:0]   r_fill;
    logic [NUM_BOX-1:0]   w_fill_nxt;
    logic [NUM_BOX-1:0]   r_s1_fill;
`endif

    assign w_load_x = (LOAD_X > c_xmax) ? c_xmax : LOAD_X;
    assign w_load_y = (LOAD_Y > c_ymax) ? c_ymax : LOAD_Y;

    // A LOAD to a box overrides its frame step; out-of-range LOAD_SEL matches no box.
    always_comb begin
`ifdef CORNICE_RIEMPI_EN
        w_fill_nxt = r_fill;
`endif
        for (int i = 0; i < NUM_BOX; i++) begin
            w_x_nxt[i]  = r_x[i];
            w_y_nxt[i]  = r_y[i];
            w_vx_nxt[i] = r_vx[i];
            w_vy_nxt[i] = r_vy[i];
            if (LOAD && (int'(LOAD_SEL) == i)) begin
                w_x_nxt[i]  = w_load_x;
                w_y_nxt[i]  = w_load_y;
                w_vx_nxt[i] = LOAD_VX;
                w_vy_nxt[i] = LOAD_VY;
`ifdef CORNICE_RIEMPI_EN
                w_fill_nxt[i] = LOAD_FILL;
`endif
            end else if (FRAME_START) begin
                w_x_nxt[i]                 = step_x(r_x[i], r_vx[i]);
                {w_vy_nxt[i], w_y_nxt[i]}  = step_y(r_y[i], r_vy[i]);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_BOX; i++) begin
                r_x[i]  <= '0;
                r_y[i]  <= '0;
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
`ifdef CORNICE_RIEMPI_EN
            r_fill <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_BOX; i++) begin
                r_x[i]  <= w_x_nxt[i];
                r_y[i]  <= w_y_nxt[i];
                r_vx[i] <= w_vx_nxt[i];
                r_vy[i] <= w_vy_nxt[i];
            end
`ifdef CORNICE_RIEMPI_EN
            r_fill <= w_fill_nxt;
`endif
        end
    end

    always_comb begin
        w_outer = '0;
        w_inner = '0;
        for (int i = 0; i < NUM_BOX; i++) begin
            {w_outer[i], w_inner[i]} = hit_flags(r_x[i], r_y[i], X_CONTROLLO, Y_CONTROLLO);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1_valid <= 1'b0;
            r_s1_outer <= '0;
            r_s1_inner <= '0;
`ifdef CORNICE_RIEMPI_EN
            r_s1_fill  <= '0;
`endif
        end else begin
            r_s1_valid <= PIX_VALID;
            r_s1_outer <= w_outer;
            r_s1_inner <= w_inner;
`ifdef CORNICE_RIEMPI_EN
            r_s1_fill  <= r_fill;
`endif
        end
    end

    // Descending scan so the lowest hit index is the last one written.
    always_comb begin
        w_hit       = 1'b0;
        w_win_inner = 1'b0;
        w_win_fill  = 1'b0;
        w_win_idx   = '0;
        for (int i = NUM_BOX - 1; i >= 0; i--) begin
            if (r_s1_outer[i]) begin
                w_hit       = 1'b1;
                w_win_inner = r_s1_inner[i];
                w_win_idx   = IW'(i);
`ifdef CORNICE_RIEMPI_EN
                w_win_fill  = r_s1_fill[i];
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_out_valid <= 1'b0;
            r_conferma  <= 1'b0;
            r_interno   <= 1'b0;
            r_indice    <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_conferma <= w_hit & (w_win_fill | ~w_win_inner);
                r_interno  <= w_win_inner & ~w_win_fill;
                r_indice   <= w_win_idx;
            end
        end
    end

    assign OUT_VALID = r_out_valid;
    assign CONFERMA  = r_conferma;
    assign INTERNO   = r_interno;
    assign INDICE    = r_indice;

endmodule
`default_nettype wire

// File: tb/tb_cornice_multi.sv
`default_nettype none
//==============================================================================
// Module   : tb_cornice_multi
// Desc     : Scoreboard bench for cornice_multi (3 boxes so an out-of-range LOAD_SEL exists).
// Revision : 1.0 - initial release
//==============================================================================
module tb_cornice_multi;
    localparam int NB = 3;
    localparam int H  = 1280;
    localparam int V  = 1024;
    localparam int L  = 100;
    localparam int A  = 100;
    localparam int S  = 6;
    localparam int VW = 6;
    localparam int IW = 2;

    logic                 CLK = 1'b0;
    logic                 RESET_N = 1'b0;
    logic                 FRAME_START = 1'b0;
    logic                 LOAD = 1'b0;
    logic [IW-1:0]        LOAD_SEL = '0;
    logic [10:0]          LOAD_X = '0;
    logic [10:0]          LOAD_Y = '0;
    logic signed [VW-1:0] LOAD_VX = '0;
    logic signed [VW-1:0] LOAD_VY = '0;
`ifdef CORNICE_RIEMPI_EN
    logic                 LOAD_FILL = 1'b0;
`endif
    logic                 PIX_VALID = 1'b0;
    logic [10:0]          X_CONTROLLO = '0;
    logic [10:0]          Y_CONTROLLO = '0;
    logic                 OUT_VALID;
    logic                 CONFERMA;
    logic                 INTERNO;
    logic [IW-1:0]        INDICE;

    typedef struct packed {
        logic          c;
        logic          i;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   mx[NB];
    int   my[NB];
    int   mvx[NB];
    int   mvy[NB];
    bit   mf[NB];

    cornice_multi #(
        .NUM_BOX(NB), .H(H), .V(V), .LARGHEZZA(L), .ALTEZZA(A), .SPESSORE(S), .VW(VW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .FRAME_START(FRAME_START), .LOAD(LOAD),
        .LOAD_SEL(LOAD_SEL), .LOAD_X(LOAD_X), .LOAD_Y(LOAD_Y),
        .LOAD_VX(LOAD_VX), .LOAD_VY(LOAD_VY),
`ifdef CORNICE_RIEMPI_EN
        .LOAD_FILL(LOAD_FILL),
`endif
        .PIX_VALID(PIX_VALID), .X_CONTROLLO(X_CONTROLLO), .Y_CONTROLLO(Y_CONTROLLO),
        .OUT_VALID(OUT_VALID), .CONFERMA(CONFERMA), .INTERNO(INTERNO), .INDICE(INDICE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic int neg_sat(int v);
        return (v == -(1 << (VW - 1))) ? ((1 << (VW - 1)) - 1) : -v;
    endfunction

    function automatic exp_t model_pixel(int px, int py);
        exp_t e;
        e = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            int dx;
            bit outer;
            bit inner;
            dx    = ((px - mx[b]) % H + H) % H;
            outer = (dx < L) && (py >= my[b]) && (py < my[b] + A);
            inner = (dx >= S) && (dx < L - S) && (py >= my[b] + S) && (py < my[b] + A - S);
            if (outer) begin
                e.c   = mf[b] | !inner;
                e.i   = inner & !mf[b];
                e.idx = IW'(b);
            end
        end
        return e;
    endfunction

    function automatic void model_frame_except(int skip);
        for (int b = 0; b < NB; b++) begin
            int xs;
            int ys;
            if (b != skip) begin
                xs = mx[b] + mvx[b];
                if (xs < 0) xs = xs + H;
                else if (xs >= H) xs = xs - H;
                mx[b] = xs;
                ys = my[b] + mvy[b];
                if (ys < 0) begin
                    my[b] = 0;
                    mvy[b] = neg_sat(mvy[b]);
                end else if (ys > V - A) begin
                    my[b] = V - A;
                    mvy[b] = neg_sat(mvy[b]);
                end else begin
                    my[b] = ys;
                end
            end
        end
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            mx[b] = 0; my[b] = 0; mvx[b] = 0; mvy[b] = 0; mf[b] = 0;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
        LOAD = 1'b0;
        FRAME_START = 1'b0;
        PIX_VALID = 1'b0;
    endtask

    task automatic set_load(int sel, int x, int y, int vx, int vy, bit f);
        LOAD = 1'b1;
        LOAD_SEL = IW'(sel);
        LOAD_X = 11'(x);
        LOAD_Y = 11'(y);
        LOAD_VX = VW'(vx);
        LOAD_VY = VW'(vy);
`ifdef CORNICE_RIEMPI_EN
        LOAD_FILL = f;
`endif
        if (sel < NB) begin
            mx[sel] = (x > H - 1) ? H - 1 : x;
            my[sel] = (y > V - A) ? V - A : y;
            mvx[sel] = vx;
            mvy[sel] = vy;
`ifdef CORNICE_RIEMPI_EN
            mf[sel] = f;
`else
            mf[sel] = 1'b0 & f;
`endif
        end
    endtask

    task automatic do_load(int sel, int x, int y, int vx, int vy, bit f);
        set_load(sel, x, y, vx, vy, f);
        step();
    endtask

    task automatic do_load_frame(int sel, int x, int y, int vx, int vy);
        set_load(sel, x, y, vx, vy, 1'b0);
        model_frame_except(sel);
        FRAME_START = 1'b1;
        step();
    endtask

    task automatic do_frame();
        model_frame_except(-1);
        FRAME_START = 1'b1;
        step();
    endtask

    task automatic set_px(int px, int py);
        PIX_VALID = 1'b1;
        X_CONTROLLO = 11'(px);
        Y_CONTROLLO = 11'(py);
    endtask

    // Directed pixel with a hand-derived expectation; frame=1 pulses FRAME_START in the same cycle.
    task automatic px_exp(int px, int py, bit c, bit i, int idx, bit frame);
        exp_t e;
        e.c = c;
        e.i = i;
        e.idx = IW'(idx);
        q.push_back(e);
        set_px(px, py);
        if (frame) begin
            model_frame_except(-1);
            FRAME_START = 1'b1;
        end
        step();
    endtask

    task automatic px_model(int px, int py, bit frame);
        q.push_back(model_pixel(px, py));
        set_px(px, py);
        if (frame) begin
            model_frame_except(-1);
            FRAME_START = 1'b1;
        end
        step();
    endtask

    task automatic drain();
        for (int n = 0; n < 10 && q.size() != 0; n++) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (RESET_N && OUT_VALID) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: OUT_VALID=1 with c=%0b i=%0b idx=%0d, expected no output",
                         CONFERMA, INTERNO, INDICE);
            end else begin
                e = q.pop_front();
                if ({CONFERMA, INTERNO, INDICE} !== {e.c, e.i, e.idx}) begin
                    errors++;
                    $display("FAIL hit_result: got c=%0b i=%0b idx=%0d, expected c=%0b i=%0b idx=%0d",
                             CONFERMA, INTERNO, INDICE, e.c, e.i, e.idx);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", OUT_VALID); end
        checks++; if (CONFERMA !== 1'b0) begin errors++; $display("FAIL rst_conferma: got %b expected 0", CONFERMA); end
        checks++; if (INTERNO !== 1'b0) begin errors++; $display("FAIL rst_interno: got %b expected 0", INTERNO); end
        checks++; if (INDICE !== '0) begin errors++; $display("FAIL rst_indice: got %0d expected 0", INDICE); end
        RESET_N = 1'b1;
        step();
        px_exp(0, 0, 1, 0, 0, 0);
        px_exp(50, 50, 0, 1, 0, 0);
        drain();
    endtask

    task automatic test_hit();
        do_load(1, 600, 800, 0, 0, 0);
        do_load(2, 900, 800, 0, 0, 0);
        do_load(0, 100, 100, 0, 0, 0);
        px_exp(100, 100, 1, 0, 0, 0);
        px_exp(150, 150, 0, 1, 0, 0);
        px_exp(99, 100, 0, 0, 0, 0);
        px_exp(199, 100, 1, 0, 0, 0);
        px_exp(200, 100, 0, 0, 0, 0);
        px_exp(100, 199, 1, 0, 0, 0);
        px_exp(100, 200, 0, 0, 0, 0);
        px_exp(106, 106, 0, 1, 0, 0);
        px_exp(105, 106, 1, 0, 0, 0);
        drain();
    endtask

    task automatic test_wrap();
        do_load(1, 1250, 100, 0, 0, 0);
        px_exp(10, 150, 0, 1, 1, 0);
        px_exp(1252, 150, 1, 0, 1, 0);
        px_exp(80, 150, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_frame_x();
        do_load(2, 1270, 500, 20, 0, 0);
        do_frame();
        px_exp(10, 510, 1, 0, 2, 0);
        px_exp(9, 550, 0, 0, 0, 0);
        do_load(2, 5, 500, -20, 0, 0);
        do_frame();
        px_exp(1265, 550, 1, 0, 2, 0);
        px_exp(1264, 550, 0, 0, 0, 0);
        px_exp(84, 550, 1, 0, 2, 0);
        px_exp(85, 550, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_bounce();
        do_load(2, 600, 920, 0, 10, 0);
        do_frame();
        px_exp(650, 924, 1, 0, 2, 0);
        px_exp(650, 923, 0, 0, 0, 0);
        do_frame();
        px_exp(650, 914, 1, 0, 2, 0);
        px_exp(650, 913, 0, 0, 0, 0);
        // Most negative velocity bounces to the most positive one.
        do_load(2, 600, 10, 0, -32, 0);
        do_frame();
        px_exp(650, 0, 1, 0, 2, 0);
        do_frame();
        px_exp(650, 31, 1, 0, 2, 0);
        px_exp(650, 30, 0, 0, 0, 0);
        // Pixel in the FRAME_START cycle sees the old position (Y=31), then Y=62.
        px_exp(650, 31, 1, 0, 2, 1);
        px_exp(650, 31, 0, 0, 0, 0);
        px_exp(650, 62, 1, 0, 2, 0);
        drain();
    endtask

    task automatic test_priority();
        do_load(0, 300, 300, 3, 0, 0);
        do_load(2, 300, 300, 0, 0, 0);
        px_exp(300, 300, 1, 0, 0, 0);
        px_exp(350, 350, 0, 1, 0, 0);
        do_load_frame(2, 500, 300, 0, 0);
        px_exp(303, 300, 1, 0, 0, 0);
        px_exp(302, 300, 0, 0, 0, 0);
        px_exp(500, 300, 1, 0, 2, 0);
        px_exp(402, 350, 1, 0, 0, 0);
        px_exp(403, 350, 0, 0, 0, 0);
        do_load(3, 0, 0, 5, 5, 0);
        px_exp(0, 0, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_clamp();
        do_load(1, 2000, 1000, 0, 0, 0);
        px_exp(1279, 924, 1, 0, 1, 0);
        px_exp(98, 1000, 1, 0, 1, 0);
        px_exp(99, 1000, 0, 0, 0, 0);
        px_exp(50, 980, 0, 1, 1, 0);
        drain();
    endtask

`ifdef CORNICE_RIEMPI_EN
    task automatic test_fill();
        do_load(0, 100, 100, 0, 0, 1);
        px_exp(150, 150, 1, 0, 0, 0);
        px_exp(100, 100, 1, 0, 0, 0);
        drain();
    endtask
`endif

    task automatic test_back_to_back();
        for (int b = 0; b < NB; b++) begin
            do_load(b, int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - A)),
                    int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                    bit'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 80; n++) begin
            int b;
            int px;
            int py;
            b  = int'($urandom_range(0, NB - 1));
            px = (mx[b] + int'($urandom_range(0, 119)) - 10 + H) % H;
            py = my[b] + int'($urandom_range(0, 119)) - 10;
            if (py < 0) py = 0;
            px_model(px, py, $urandom_range(0, 5) == 0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        set_px(10, 10);
        step();
        set_px(20, 20);
        step();
        checks++;
        if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", OUT_VALID); end
        #1 RESET_N = 1'b0;
        #1;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", OUT_VALID); end
        checks++; if (CONFERMA !== 1'b0) begin errors++; $display("FAIL midrst_conferma: got %b expected 0", CONFERMA); end
        checks++; if (INTERNO !== 1'b0) begin errors++; $display("FAIL midrst_interno: got %b expected 0", INTERNO); end
        checks++; if (INDICE !== '0) begin errors++; $display("FAIL midrst_indice: got %0d expected 0", INDICE); end
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        model_reset();
        for (int n = 0; n < 4; n++) begin
            @(negedge CLK);
            checks++;
            if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL late_output: cycle %0d OUT_VALID=%b expected 0", n, OUT_VALID); end
        end
        @(posedge CLK);
        #1;
        px_exp(0, 0, 1, 0, 0, 0);
        px_exp(50, 50, 0, 1, 0, 0);
        do_frame();
        px_exp(99, 99, 1, 0, 0, 0);
        px_exp(100, 50, 0, 0, 0, 0);
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hit();
        test_wrap();
        test_frame_x();
        test_bounce();
        test_priority();
        test_clamp();
`ifdef CORNICE_RIEMPI_EN
        test_fill();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
